instr_fetch_unit: RTL and testbench

//  Fetch stage that sits immediately upstream of the instruction decoder. It owns the

---
 rtl/harvard_pkg.sv | 50 +++++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/instr_fetch_unit.sv | 135 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/harvard_pkg.sv
// Shared definitions for the Harvard core front end: opcode map, instruction
// field positions, default widths and the fetch-stage state encoding.
package harvard_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 32;

    localparam logic [5:0] OP_MOV_I = 6'h00;
    localparam logic [5:0] OP_MOV_R = 6'h01;
    localparam logic [5:0] OP_ADD   = 6'h02;
    localparam logic [5:0] OP_SUB   = 6'h03;
    localparam logic [5:0] OP_AND   = 6'h04;
    localparam logic [5:0] OP_OR    = 6'h05;
    localparam logic [5:0] OP_XOR   = 6'h06;
    localparam logic [5:0] OP_NOT   = 6'h07;
    localparam logic [5:0] OP_LD    = 6'h08;
    localparam logic [5:0] OP_ST    = 6'h09;
    localparam logic [5:0] OP_BEQ   = 6'h0A;
    localparam logic [5:0] OP_BNE   = 6'h0B;
    localparam logic [5:0] OP_JMP   = 6'h0C;
    localparam logic [5:0] OP_CMP   = 6'h0D;
    localparam logic [5:0] OP_LSH   = 6'h0E;
    localparam logic [5:0] OP_RSH   = 6'h0F;
    localparam logic [5:0] OP_LRSH  = 6'h10;
    localparam logic [5:0] OP_MAX   = 6'h10;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RDST2_HI = 25;
    localparam int RDST2_LO = 21;
    localparam int RDST1_HI = 20;
    localparam int RDST1_LO = 16;
    localparam int RSRC2_HI = 9;
    localparam int RSRC2_LO = 5;
    localparam int RSRC1_HI = 4;
    localparam int RSRC1_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    function automatic logic is_illegal(input logic [5:0] opc);
        return opc > OP_MAX;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO between imem responses and the decoder; the head entry
// is read straight from storage registers so outputs carry no input-to-output path.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output logic [W-1:0]             head_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & (count != '0);
    assign do_push = push & (count != FULL_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited in-order imem reads, queues
// tagged words for the decoder and discards in-flight responses after a redirect.
module instr_fetch_unit
    import harvard_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      imem_req_valid,
    input  logic                      imem_req_ready,
    output logic [ADDR_W-1:0]         imem_addr,
    input  logic                      imem_rsp_valid,
    input  logic [INSTR_W-1:0]        imem_rsp_data,
    input  logic                      redirect_valid,
    input  logic [ADDR_W-1:0]         redirect_pc,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [INSTR_W-1:0]        instr_code,
    output logic [ADDR_W-1:0]         instr_pc,
    output logic                      instr_illegal,
    output fetch_state_e              dbg_state,
    output logic [$clog2(DEPTH):0]    dbg_drop_cnt
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and payload is stable while valid waits.

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CREDIT = CNT_W'(DEPTH);

    fetch_state_e                state;
    logic [ADDR_W-1:0]           pc;
    logic [ADDR_W-1:0]           rsp_pc;
    logic [CNT_W-1:0]            outstanding;
    logic [CNT_W-1:0]            drop_cnt;
    logic [CNT_W-1:0]            drop_next;
    logic [CNT_W-1:0]            out_after_rsp;
    logic [CNT_W-1:0]            count;
    logic                        req_fire;
    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        head_valid;
    logic [INSTR_W+ADDR_W-1:0]   head_data;

    // Credit counts both queued words and reads still in flight, so every
    // returning response is guaranteed a FIFO slot.
    assign imem_req_valid = (state == ST_RUN) & ~redirect_valid & ((count + outstanding) < CREDIT);
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign out_after_rsp  = outstanding - CNT_W'(imem_rsp_valid);
    assign fifo_push      = imem_rsp_valid & (drop_cnt == '0) & ~redirect_valid;
    assign fifo_pop       = instr_ready & head_valid & ~redirect_valid;

    // A redirect from RUN converts every still-pending read into a drop; a
    // redirect arriving mid-flush leaves the drop count to drain on its own.
    always_comb begin
        drop_next = drop_cnt;
        if (redirect_valid && (state != ST_FLUSH)) begin
            drop_next = out_after_rsp;
        end else if (imem_rsp_valid && (drop_cnt != '0)) begin
            drop_next = drop_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
            drop_cnt    <= drop_next;
            if (redirect_valid) begin
                pc     <= redirect_pc;
                rsp_pc <= redirect_pc;
            end else begin
                if (req_fire) begin
                    pc <= pc + 1'b1;
                end
                if (fifo_push) begin
                    rsp_pc <= rsp_pc + 1'b1;
                end
            end
            case (state)
                ST_IDLE: state <= ST_RUN;
                ST_RUN: begin
                    if (redirect_valid && (out_after_rsp != '0)) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (drop_next == '0) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (INSTR_W + ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_data  ({imem_rsp_data, rsp_pc}),
        .pop        (fifo_pop),
        .flush      (redirect_valid),
        .count      (count),
        .head_valid (head_valid),
        .head_data  (head_data)
    );

    assign instr_valid   = head_valid;
    assign instr_code    = head_data[INSTR_W+ADDR_W-1:ADDR_W];
    assign instr_pc      = head_data[ADDR_W-1:0];
    assign instr_illegal = head_valid & is_illegal(instr_code[OPC_HI:OPC_LO]);

    assign dbg_state     = state;
    assign dbg_drop_cnt  = drop_cnt;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && (count == CREDIT)))
        else $fatal(1, "fetch_fifo overflow");

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: an in-order memory model with random latency and
// a program-order scoreboard that predicts which PC must reach the decoder next.
module tb_instr_fetch_unit;
    import harvard_pkg::*;

    localparam int AW = 8;
    localparam int IW = 32;
    localparam int DEPTH = 4;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              imem_req_valid;
    logic              imem_req_ready = 1'b0;
    logic [AW-1:0]     imem_addr;
    logic              imem_rsp_valid = 1'b0;
    logic [IW-1:0]     imem_rsp_data = '0;
    logic              redirect_valid = 1'b0;
    logic [AW-1:0]     redirect_pc = '0;
    logic              instr_valid;
    logic              instr_ready = 1'b0;
    logic [IW-1:0]     instr_code;
    logic [AW-1:0]     instr_pc;
    logic              instr_illegal;
    fetch_state_e      dbg_state;
    logic [CW-1:0]     dbg_drop_cnt;

    instr_fetch_unit #(
        .ADDR_W   (AW),
        .INSTR_W  (IW),
        .DEPTH    (DEPTH),
        .RESET_PC (8'h00)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_code     (instr_code),
        .instr_pc       (instr_pc),
        .instr_illegal  (instr_illegal),
        .dbg_state      (dbg_state),
        .dbg_drop_cnt   (dbg_drop_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- shared state ----------------
    int            pass_cnt = 0;
    int            chk_cnt = 0;
    int            n_out = 0;
    int            rsp_pct = 100;
    int            rdy_pct = 100;
    logic [IW-1:0] mem [256];
    logic [AW-1:0] pend_q[$];
    logic [AW-1:0] req_q[$];
    logic [AW-1:0] exp_pc = '0;
    logic [AW-1:0] mem_a;

    // ---------------- memory model ----------------
    // Responses are in order; a read accepted at one edge may answer at the next.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                pend_q.delete();
                imem_rsp_valid = 1'b0;
                imem_req_ready = 1'b0;
            end else begin
                if (pend_q.size() > 0 && $urandom_range(0, 99) < rsp_pct) begin
                    mem_a = pend_q.pop_front();
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data = mem[mem_a];
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data = $urandom();
                end
                imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
                #1;
                if (imem_req_valid === 1'b1 && imem_req_ready) begin
                    pend_q.push_back(imem_addr);
                    req_q.push_back(imem_addr);
                end
            end
        end
    end

    // ---------------- driver + scoreboard ----------------
    // One cycle: drive decoder/redirect inputs, and if a word is consumed check
    // it against the next PC in program order.
    task automatic step(input logic rdy, input logic redir, input logic [AW-1:0] rpc);
        logic [IW-1:0] w;
        @(negedge clk);
        instr_ready = rdy;
        redirect_valid = redir;
        redirect_pc = rpc;
        #3;
        if (instr_valid === 1'b1 && rdy && !redir) begin
            w = mem[exp_pc];
            chk_cnt++;
            if (instr_pc !== exp_pc || instr_code !== w || instr_illegal !== (w[31:26] > 6'h10))
                $display("FAIL stream: got pc=%h code=%h ill=%b, expected pc=%h code=%h ill=%b",
                         instr_pc, instr_code, instr_illegal, exp_pc, w, (w[31:26] > 6'h10));
            else
                pass_cnt++;
            exp_pc = exp_pc + 1'b1;
            n_out++;
        end
        if (redir) exp_pc = rpc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        pend_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_pc = 8'h00;
        n_out = 0;
        req_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        chk_cnt++;
        if (imem_req_valid !== 1'b0 || imem_addr !== 8'h00)
            $display("FAIL reset_req: got valid=%b addr=%h, expected 0/00", imem_req_valid, imem_addr);
        else pass_cnt++;
        chk_cnt++;
        if (instr_valid !== 1'b0 || instr_code !== 32'h0 || instr_pc !== 8'h00 || instr_illegal !== 1'b0)
            $display("FAIL reset_out: got v=%b code=%h pc=%h ill=%b, expected all zero",
                     instr_valid, instr_code, instr_pc, instr_illegal);
        else pass_cnt++;
        chk_cnt++;
        if (dbg_state !== ST_IDLE || dbg_drop_cnt !== 3'd0)
            $display("FAIL reset_state: got state=%0d drop=%0d, expected IDLE/0", dbg_state, dbg_drop_cnt);
        else pass_cnt++;
        rst_n = 1'b1;
        exp_pc = 8'h00;
        n_out = 0;
        req_q.delete();
    endtask

    task automatic test_stream();
        rsp_pct = 100;
        rdy_pct = 100;
        step(1'b1, 1'b0, 8'h00);
        chk_cnt++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 8'h00 || dbg_state !== ST_RUN)
            $display("FAIL first_req: got valid=%b addr=%h state=%0d, expected 1/00/RUN",
                     imem_req_valid, imem_addr, dbg_state);
        else pass_cnt++;
        repeat (14) step(1'b1, 1'b0, 8'h00);
        chk_cnt++;
        if (n_out !== 13)
            $display("FAIL stream_count: got %0d words, expected 13", n_out);
        else pass_cnt++;
        chk_cnt++;
        if (req_q.size() < 4 || req_q[0] !== 8'h00 || req_q[1] !== 8'h01 || req_q[3] !== 8'h03)
            $display("FAIL stream_addrs: got %0d requests starting %h, expected 00,01,02,03..",
                     req_q.size(), (req_q.size() > 0) ? req_q[0] : 8'hxx);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (10) step(1'b0, 1'b0, 8'h00);
        chk_cnt++;
        if (req_q.size() !== 4 || req_q[0] !== 8'h00 || req_q[3] !== 8'h03)
            $display("FAIL bp_requests: got %0d requests, expected 4 (pc 00..03)", req_q.size());
        else pass_cnt++;
        chk_cnt++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 8'h00)
            $display("FAIL bp_hold: got req_valid=%b v=%b pc=%h, expected 0/1/00",
                     imem_req_valid, instr_valid, instr_pc);
        else pass_cnt++;
        repeat (20) step(1'b1, 1'b0, 8'h00);
        chk_cnt++;
        if (n_out !== 20)
            $display("FAIL bp_release: got %0d words, expected 20 without gaps", n_out);
        else pass_cnt++;
    endtask

    task automatic test_redirect_flush();
        do_reset();
        rsp_pct = 0;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk_cnt++;
        if (req_q.size() !== 2)
            $display("FAIL flush_setup: got %0d outstanding requests, expected 2", req_q.size());
        else pass_cnt++;
        step(1'b1, 1'b1, 8'h40);
        rsp_pct = 100;
        step(1'b1, 1'b0, 8'h00);
        chk_cnt++;
        if (dbg_state !== ST_FLUSH || dbg_drop_cnt !== 3'd2 || instr_valid !== 1'b0 || imem_req_valid !== 1'b0)
            $display("FAIL flush_enter: got state=%0d drop=%0d v=%b req=%b, expected FLUSH/2/0/0",
                     dbg_state, dbg_drop_cnt, instr_valid, imem_req_valid);
        else pass_cnt++;
        step(1'b1, 1'b0, 8'h00);
        chk_cnt++;
        if (dbg_state !== ST_FLUSH || dbg_drop_cnt !== 3'd1 || instr_valid !== 1'b0)
            $display("FAIL flush_mid: got state=%0d drop=%0d v=%b, expected FLUSH/1/0",
                     dbg_state, dbg_drop_cnt, instr_valid);
        else pass_cnt++;
        step(1'b1, 1'b0, 8'h00);
        chk_cnt++;
        if (dbg_state !== ST_RUN || imem_req_valid !== 1'b1 || imem_addr !== 8'h40)
            $display("FAIL flush_exit: got state=%0d req=%b addr=%h, expected RUN/1/40",
                     dbg_state, imem_req_valid, imem_addr);
        else pass_cnt++;
        repeat (9) step(1'b1, 1'b0, 8'h00);
        chk_cnt++;
        if (n_out !== 8)
            $display("FAIL flush_resume: got %0d words, expected 8 from pc 40", n_out);
        else pass_cnt++;
    endtask

    task automatic test_redirect_collide();
        do_reset();
        rsp_pct = 100;
        repeat (3) step(1'b0, 1'b0, 8'h00);
        rsp_pct = 0;
        step(1'b0, 1'b0, 8'h00);
        chk_cnt++;
        if (req_q.size() !== 4 || instr_valid !== 1'b1 || instr_pc !== 8'h00)
            $display("FAIL collide_setup: got reqs=%0d v=%b pc=%h, expected 4/1/00",
                     req_q.size(), instr_valid, instr_pc);
        else pass_cnt++;
        rsp_pct = 100;
        step(1'b1, 1'b1, 8'h90);
        chk_cnt++;
        if (imem_req_valid !== 1'b0)
            $display("FAIL collide_noreq: got req_valid=%b, expected 0", imem_req_valid);
        else pass_cnt++;
        step(1'b1, 1'b0, 8'h00);
        chk_cnt++;
        if (dbg_state !== ST_FLUSH || dbg_drop_cnt !== 3'd1 || instr_valid !== 1'b0)
            $display("FAIL collide_drop: got state=%0d drop=%0d v=%b, expected FLUSH/1/0",
                     dbg_state, dbg_drop_cnt, instr_valid);
        else pass_cnt++;
        step(1'b1, 1'b0, 8'h00);
        chk_cnt++;
        if (dbg_state !== ST_RUN || dbg_drop_cnt !== 3'd0 || imem_addr !== 8'h90)
            $display("FAIL collide_exit: got state=%0d drop=%0d addr=%h, expected RUN/0/90",
                     dbg_state, dbg_drop_cnt, imem_addr);
        else pass_cnt++;
        repeat (7) step(1'b1, 1'b0, 8'h00);
        chk_cnt++;
        if (n_out !== 6)
            $display("FAIL collide_resume: got %0d words, expected 6 from pc 90", n_out);
        else pass_cnt++;
    endtask

    task automatic test_pc_wrap();
        rsp_pct = 100;
        rdy_pct = 100;
        n_out = 0;
        req_q.delete();
        step(1'b1, 1'b1, 8'hFE);
        repeat (12) step(1'b1, 1'b0, 8'h00);
        chk_cnt++;
        if (req_q.size() < 4 || req_q[0] !== 8'hFE || req_q[1] !== 8'hFF || req_q[2] !== 8'h00 || req_q[3] !== 8'h01)
            $display("FAIL wrap_addrs: got %0d requests starting %h, expected FE,FF,00,01",
                     req_q.size(), (req_q.size() > 0) ? req_q[0] : 8'hxx);
        else pass_cnt++;
        chk_cnt++;
        if (n_out < 4)
            $display("FAIL wrap_words: got %0d words, expected at least 4 across the wrap", n_out);
        else pass_cnt++;
    endtask

    task automatic test_illegal_and_reset();
        logic found;
        rsp_pct = 100;
        rdy_pct = 100;
        mem[8'h20] = {6'h11, 26'($urandom())};
        mem[8'h21] = {6'h10, 26'($urandom())};
        step(1'b0, 1'b1, 8'h20);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step(1'b0, 1'b0, 8'h00);
            if (instr_valid === 1'b1) found = 1'b1;
        end
        chk_cnt++;
        if (!found || instr_pc !== 8'h20 || instr_illegal !== 1'b1)
            $display("FAIL illegal_11: got found=%b pc=%h ill=%b, expected 1/20/1", found, instr_pc, instr_illegal);
        else pass_cnt++;
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk_cnt++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h21 || instr_illegal !== 1'b0)
            $display("FAIL illegal_10: got v=%b pc=%h ill=%b, expected 1/21/0", instr_valid, instr_pc, instr_illegal);
        else pass_cnt++;
        repeat (5) step(1'($urandom_range(0, 1)), 1'b0, 8'h00);
        // asynchronous reset in the middle of a clock phase
        @(negedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (instr_valid !== 1'b0 || instr_code !== 32'h0 || instr_pc !== 8'h00 || instr_illegal !== 1'b0 ||
            imem_req_valid !== 1'b0 || imem_addr !== 8'h00 || dbg_state !== ST_IDLE || dbg_drop_cnt !== 3'd0)
            $display("FAIL async_reset: got v=%b code=%h pc=%h ill=%b req=%b addr=%h state=%0d, expected reset values",
                     instr_valid, instr_code, instr_pc, instr_illegal, imem_req_valid, imem_addr, dbg_state);
        else pass_cnt++;
        pend_q.delete();
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_pc = 8'h00;
        n_out = 0;
        req_q.delete();
        step(1'b1, 1'b0, 8'h00);
        chk_cnt++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 8'h00)
            $display("FAIL restart: got req=%b addr=%h, expected 1/00", imem_req_valid, imem_addr);
        else pass_cnt++;
        repeat (10) step(1'b1, 1'b0, 8'h00);
        chk_cnt++;
        if (n_out !== 9)
            $display("FAIL restart_words: got %0d words, expected 9 from pc 00", n_out);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [AW-1:0] exp_req;
        logic [AW-1:0] a;
        logic          redir;
        logic [AW-1:0] rpc;
        do_reset();
        exp_req = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                rsp_pct = $urandom_range(30, 100);
                rdy_pct = $urandom_range(30, 100);
            end
            redir = ($urandom_range(0, 99) < 3);
            rpc = 8'($urandom());
            step(($urandom_range(0, 99) < 70), redir, rpc);
            while (req_q.size() > 0) begin
                a = req_q.pop_front();
                chk_cnt++;
                if (a !== exp_req)
                    $display("FAIL req_order: got addr=%h, expected %h", a, exp_req);
                else pass_cnt++;
                exp_req = exp_req + 1'b1;
            end
            if (redir) exp_req = rpc;
        end
        chk_cnt++;
        if (n_out < 50)
            $display("FAIL random_progress: got %0d words, expected at least 50", n_out);
        else pass_cnt++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_collide();
        test_pc_wrap();
        test_illegal_and_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
